// File: rtl/bin_to_bcd_seq_if.sv
// Handshake and result bundle between a binary-to-BCD converter and its user.
// The requester drives the master side and the converter sits on the slave side.
interface bin_to_bcd_seq_if #(
  parameter int BIN_W  = 12,
  parameter int DIGITS = 4
);
  logic                  start;
  logic [BIN_W-1:0]      bin_d_in;
  logic                  busy;
  logic                  rdy;
  logic [4*DIGITS-1:0]   bcd_d_out;
  logic                  neg;
  logic                  ovf;
  logic [DIGITS-1:0]     blank_mask;

  modport master (
    output start, bin_d_in,
    input  busy, rdy, bcd_d_out, neg, ovf, blank_mask
  );

  modport slave (
    input  start, bin_d_in,
    output busy, rdy, bcd_d_out, neg, ovf, blank_mask
  );
endinterface

// File: rtl/bin_to_bcd_seq.sv
// Iterative shift-and-add-3 binary-to-BCD converter, one bit per clock.
// Optional two's-complement input, sticky overflow and leading-zero blanking.
module bin_to_bcd_seq #(
  parameter int BIN_W       = 12,
  parameter int DIGITS      = 4,
  parameter int SIGNED_MODE = 0
) (
  input  logic             clk,
  input  logic             rst,
  bin_to_bcd_seq_if.slave  bus
);
  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q;
  logic [BIN_W-1:0]   bin_q;
  logic [BCD_W-1:0]   bcd_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               sign_q;
  logic               ovf_sticky_q;

  logic               busy_q;
  logic               rdy_q;
  logic [BCD_W-1:0]   bcd_out_q;
  logic               neg_q;
  logic               ovf_q;
  logic [DIGITS-1:0]  blank_q;

  // Magnitude of the incoming operand; -2^(BIN_W-1) wraps to the unsigned 2^(BIN_W-1).
  logic               in_neg_d;
  logic [BIN_W-1:0]   mag_d;

  assign in_neg_d = (SIGNED_MODE != 0) && bus.bin_d_in[BIN_W-1];
  assign mag_d    = in_neg_d ? (~bus.bin_d_in + BIN_W'(1)) : bus.bin_d_in;

  logic [BCD_W-1:0]   bcd_adj;
  logic [BCD_W-1:0]   bcd_d;
  logic [BIN_W-1:0]   bin_d;
  logic               carry_d;
  logic [DIGITS-1:0]  zero_above;
  logic [DIGITS-1:0]  blank_d;

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      // Digits are corrected independently; no carry crosses a digit boundary.
      assign bcd_adj[4*gi +: 4] = (bcd_q[4*gi +: 4] > 4'd4) ? (bcd_q[4*gi +: 4] + 4'd3)
                                                             : bcd_q[4*gi +: 4];
      if (gi == DIGITS - 1) begin : g_top
        assign zero_above[gi] = (bcd_q[4*gi +: 4] == 4'd0);
      end else begin : g_low
        assign zero_above[gi] = (bcd_q[4*gi +: 4] == 4'd0) && zero_above[gi+1];
      end
    end
  endgenerate

  // The bit leaving the top digit is a carry into a digit we do not have.
  assign {carry_d, bcd_d, bin_d} = {bcd_adj, bin_q, 1'b0};
  assign blank_d = zero_above & ~DIGITS'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      bin_q        <= '0;
      bcd_q        <= '0;
      cnt_q        <= '0;
      sign_q       <= 1'b0;
      ovf_sticky_q <= 1'b0;
      busy_q       <= 1'b0;
      rdy_q        <= 1'b0;
      bcd_out_q    <= '0;
      neg_q        <= 1'b0;
      ovf_q        <= 1'b0;
      blank_q      <= '0;
    end else begin
      rdy_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            bin_q        <= mag_d;
            sign_q       <= in_neg_d;
            bcd_q        <= '0;
            ovf_sticky_q <= 1'b0;
            cnt_q        <= '0;
            busy_q       <= 1'b1;
            state_q      <= CONV;
          end
        end
        CONV: begin
          bcd_q        <= bcd_d;
          bin_q        <= bin_d;
          ovf_sticky_q <= ovf_sticky_q | carry_d;
          cnt_q        <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(BIN_W - 1)) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          bcd_out_q <= bcd_q;
          neg_q     <= sign_q;
          ovf_q     <= ovf_sticky_q;
          blank_q   <= blank_d;
          rdy_q     <= 1'b1;
          busy_q    <= 1'b0;
          state_q   <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy       = busy_q;
  assign bus.rdy        = rdy_q;
  assign bus.bcd_d_out  = bcd_out_q;
  assign bus.neg        = neg_q;
  assign bus.ovf        = ovf_q;
  assign bus.blank_mask = blank_q;
endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed bench for bin_to_bcd_seq across three configurations:
// 12-bit/4-digit unsigned, 8-bit/3-digit signed, 8-bit/2-digit unsigned.
module tb_bin_to_bcd_seq;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  bin_to_bcd_seq_if #(.BIN_W(12), .DIGITS(4)) ia ();
  bin_to_bcd_seq_if #(.BIN_W(8),  .DIGITS(3)) ib ();
  bin_to_bcd_seq_if #(.BIN_W(8),  .DIGITS(2)) ic ();

  bin_to_bcd_seq #(.BIN_W(12), .DIGITS(4), .SIGNED_MODE(0)) u_a (.clk(clk), .rst(rst), .bus(ia.slave));
  bin_to_bcd_seq #(.BIN_W(8),  .DIGITS(3), .SIGNED_MODE(1)) u_b (.clk(clk), .rst(rst), .bus(ib.slave));
  bin_to_bcd_seq #(.BIN_W(8),  .DIGITS(2), .SIGNED_MODE(0)) u_c (.clk(clk), .rst(rst), .bus(ic.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %-14s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic drive(input int which, input logic s, input logic [11:0] v);
    case (which)
      0:       begin ia.start = s; ia.bin_d_in = v;      end
      1:       begin ib.start = s; ib.bin_d_in = v[7:0]; end
      default: begin ic.start = s; ic.bin_d_in = v[7:0]; end
    endcase
  endtask

  function automatic logic rdy_of(input int which);
    case (which)
      0:       return ia.rdy;
      1:       return ib.rdy;
      default: return ic.rdy;
    endcase
  endfunction

  // Start one conversion and count edges from acceptance until rdy is seen.
  task automatic conv(input int which, input logic [11:0] v, output int lat);
    @(negedge clk);
    drive(which, 1'b1, v);
    @(posedge clk);
    #1;
    drive(which, 1'b0, ~v);
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      #1;
    end while (rdy_of(which) !== 1'b1 && lat < 40);
  endtask

  int lat;
  int n_rdy;
  int t_first;
  int t_second;
  logic [15:0] cap_bcd;

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    drive(0, 1'b0, 12'd0);
    drive(1, 1'b0, 12'd0);
    drive(2, 1'b0, 12'd0);
    #12;
    chk("rst_busy",  {31'd0, ia.busy}, 32'd0);
    chk("rst_rdy",   {31'd0, ia.rdy}, 32'd0);
    chk("rst_bcd",   {16'd0, ia.bcd_d_out}, 32'd0);
    chk("rst_flags", {29'd0, ia.neg, ia.ovf, ib.neg}, 32'd0);
    chk("rst_blank", {28'd0, ia.blank_mask}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // 12-bit unsigned
    conv(0, 12'd4095, lat);
    chk("a4095_lat",   lat, 32'd13);
    chk("a4095_bcd",   {16'd0, ia.bcd_d_out}, 32'h4095);
    chk("a4095_ovf",   {31'd0, ia.ovf}, 32'd0);
    chk("a4095_neg",   {31'd0, ia.neg}, 32'd0);
    chk("a4095_blank", {28'd0, ia.blank_mask}, 32'b0000);
    chk("a4095_busy",  {31'd0, ia.busy}, 32'd0);
    @(posedge clk); #1;
    chk("a4095_rdy1c", {31'd0, ia.rdy}, 32'd0);
    chk("a_hold",      {16'd0, ia.bcd_d_out}, 32'h4095);

    conv(0, 12'd0, lat);
    chk("a0_bcd",    {16'd0, ia.bcd_d_out}, 32'h0000);
    chk("a0_blank",  {28'd0, ia.blank_mask}, 32'b1110);
    conv(0, 12'd7, lat);
    chk("a7_bcd",    {16'd0, ia.bcd_d_out}, 32'h0007);
    chk("a7_blank",  {28'd0, ia.blank_mask}, 32'b1110);
    conv(0, 12'd305, lat);
    chk("a305_bcd",  {16'd0, ia.bcd_d_out}, 32'h0305);
    chk("a305_blank",{28'd0, ia.blank_mask}, 32'b1000);

    // 8-bit signed, 3 digits
    conv(1, 12'h080, lat);
    chk("b80_lat",   lat, 32'd9);
    chk("b80_bcd",   {20'd0, ib.bcd_d_out}, 32'h128);
    chk("b80_neg",   {31'd0, ib.neg}, 32'd1);
    conv(1, 12'h0FF, lat);
    chk("bFF_bcd",   {20'd0, ib.bcd_d_out}, 32'h001);
    chk("bFF_neg",   {31'd0, ib.neg}, 32'd1);
    chk("bFF_blank", {29'd0, ib.blank_mask}, 32'b110);
    conv(1, 12'h07F, lat);
    chk("b7F_bcd",   {20'd0, ib.bcd_d_out}, 32'h127);
    chk("b7F_neg",   {31'd0, ib.neg}, 32'd0);
    conv(1, 12'h000, lat);
    chk("b00_neg",   {31'd0, ib.neg}, 32'd0);
    chk("b00_bcd",   {20'd0, ib.bcd_d_out}, 32'h000);

    // 8-bit unsigned, 2 digits: overflow and its per-conversion clear
    conv(2, 12'd255, lat);
    chk("c255_bcd",  {24'd0, ic.bcd_d_out}, 32'h55);
    chk("c255_ovf",  {31'd0, ic.ovf}, 32'd1);
    conv(2, 12'd99, lat);
    chk("c99_bcd",   {24'd0, ic.bcd_d_out}, 32'h99);
    chk("c99_ovf",   {31'd0, ic.ovf}, 32'd0);

    // start pulse during busy must be ignored
    @(negedge clk);
    drive(0, 1'b1, 12'd4095);
    @(posedge clk); #1;
    drive(0, 1'b0, 12'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    drive(0, 1'b1, 12'd1);
    @(negedge clk);
    drive(0, 1'b0, 12'd0);
    n_rdy = 0;
    cap_bcd = '0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (ia.rdy === 1'b1) begin
        n_rdy++;
        cap_bcd = ia.bcd_d_out;
      end
    end
    chk("busy_n_rdy",  n_rdy, 32'd1);
    chk("busy_bcd",    {16'd0, cap_bcd}, 32'h4095);
    chk("busy_idle",   {31'd0, ia.busy}, 32'd0);

    // start held high: back-to-back conversions every BIN_W+2 cycles
    @(negedge clk);
    drive(0, 1'b1, 12'd50);
    t_first = -1;
    t_second = -1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (ia.rdy === 1'b1) begin
        if (t_first < 0) t_first = i;
        else if (t_second < 0) t_second = i;
      end
    end
    drive(0, 1'b0, 12'd0);
    chk("held_gap",    t_second - t_first, 32'd14);
    chk("held_bcd",    {16'd0, ia.bcd_d_out}, 32'h0050);

    // asynchronous reset mid-conversion
    conv(0, 12'd0, lat);
    @(negedge clk);
    drive(0, 1'b1, 12'd999);
    @(posedge clk); #1;
    drive(0, 1'b0, 12'd0);
    repeat (5) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_busy",   {31'd0, ia.busy}, 32'd0);
    chk("arst_bcd_b",  {20'd0, ib.bcd_d_out}, 32'd0);
    chk("arst_ovfneg", {30'd0, ic.ovf, ib.neg}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    n_rdy = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (ia.rdy === 1'b1) n_rdy++;
    end
    chk("arst_no_rdy", n_rdy, 32'd0);
    conv(0, 12'd1234, lat);
    chk("a1234_lat",   lat, 32'd13);
    chk("a1234_bcd",   {16'd0, ia.bcd_d_out}, 32'h1234);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
